// File: rtl/mem_access.sv
// Memory stage: accepts one execute result per transfer, performs a word-wide
// data-memory access over a req/ack handshake, and emits a one-cycle
// writeback packet for the register-file write port.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   in_valid/in_ready               upstream handshake (in_ready from state)
//   data, store_data                result/address, store word
//   mem_read_enabled/mem_write_enabled, reg_write_enabled, reg_write_dest
//   dmem_req/we/addr/wdata          memory request, held until ack or timeout
//   dmem_ack/rdata                  memory completion and read data
//   wb_valid, wb_reg_write_enabled, wb_reg_write_dest, wb_data  writeback
//   mem_err                         pulse on misaligned access or timeout
module mem_access #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data,
  input  logic [31:0] store_data,
  input  logic        mem_read_enabled,
  input  logic        mem_write_enabled,
  input  logic        reg_write_enabled,
  input  logic [5:0]  reg_write_dest,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write_enabled,
  output logic [5:0]  wb_reg_write_dest,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              lat_en, lat_en_nxt;
  logic              req_nxt, we_nxt, wb_valid_nxt, wb_we_nxt, err_nxt;
  logic [31:0]       addr_nxt, wdata_nxt, wb_data_nxt;
  logic [5:0]        wb_dest_nxt;

  logic is_mem, is_store, accept, timeout;

  // Acceptance only in IDLE and never while reset is asserted.
  assign in_ready = (state == IDLE) & rstn;

  assign accept   = in_valid & in_ready;
  assign is_store = mem_write_enabled;
  assign is_mem   = mem_read_enabled | mem_write_enabled;
  assign timeout  = (cnt == CNT_W'(MEM_TIMEOUT - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lat_en_nxt   = lat_en;
    req_nxt      = dmem_req;
    we_nxt       = dmem_we;
    addr_nxt     = dmem_addr;
    wdata_nxt    = dmem_wdata;
    wb_valid_nxt = 1'b0;
    err_nxt      = 1'b0;
    wb_we_nxt    = wb_reg_write_enabled;
    wb_dest_nxt  = wb_reg_write_dest;
    wb_data_nxt  = wb_data;

    case (state)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_nxt = 1'b1;
            wb_data_nxt  = data;
            wb_dest_nxt  = reg_write_dest;
            wb_we_nxt    = reg_write_enabled & (reg_write_dest != 6'd0);
          end else if (data[1:0] != 2'b00) begin
            wb_valid_nxt = 1'b1;
            wb_data_nxt  = data;
            wb_dest_nxt  = reg_write_dest;
            wb_we_nxt    = 1'b0;
            err_nxt      = 1'b1;
          end else begin
            req_nxt     = 1'b1;
            we_nxt      = is_store;
            addr_nxt    = data;
            wdata_nxt   = store_data;
            wb_dest_nxt = reg_write_dest;
            // A store never writes the register file, even if asked to.
            lat_en_nxt  = reg_write_enabled & ~is_store;
            cnt_nxt     = '0;
            state_nxt   = WAIT;
          end
        end
      end
      WAIT: begin
        // Ack takes priority over a timeout in the same cycle.
        if (dmem_ack) begin
          req_nxt      = 1'b0;
          wb_valid_nxt = 1'b1;
          wb_data_nxt  = dmem_we ? dmem_addr : dmem_rdata;
          wb_we_nxt    = lat_en & ~dmem_we & (wb_reg_write_dest != 6'd0);
          state_nxt    = IDLE;
        end else if (timeout) begin
          req_nxt      = 1'b0;
          wb_valid_nxt = 1'b1;
          wb_data_nxt  = dmem_addr;
          wb_we_nxt    = 1'b0;
          err_nxt      = 1'b1;
          state_nxt    = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                <= IDLE;
      cnt                  <= '0;
      lat_en               <= 1'b0;
      dmem_req             <= 1'b0;
      dmem_we              <= 1'b0;
      dmem_addr            <= 32'd0;
      dmem_wdata           <= 32'd0;
      wb_valid             <= 1'b0;
      wb_reg_write_enabled <= 1'b0;
      wb_reg_write_dest    <= 6'd0;
      wb_data              <= 32'd0;
      mem_err              <= 1'b0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      lat_en               <= lat_en_nxt;
      dmem_req             <= req_nxt;
      dmem_we              <= we_nxt;
      dmem_addr            <= addr_nxt;
      dmem_wdata           <= wdata_nxt;
      wb_valid             <= wb_valid_nxt;
      wb_reg_write_enabled <= wb_we_nxt;
      wb_reg_write_dest    <= wb_dest_nxt;
      wb_data              <= wb_data_nxt;
      mem_err              <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboarded bench for mem_access (MEM_TIMEOUT=4): stimulus pushes the
// expected writeback packet, a negedge monitor pops and compares on wb_valid.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data, store_data;
  logic        mem_read_enabled, mem_write_enabled, reg_write_enabled;
  logic [5:0]  reg_write_dest;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_reg_write_enabled;
  logic [5:0]  wb_reg_write_dest;
  logic [31:0] wb_data;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [5:0]  dest;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  mem_access #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .store_data(store_data),
    .mem_read_enabled(mem_read_enabled), .mem_write_enabled(mem_write_enabled),
    .reg_write_enabled(reg_write_enabled), .reg_write_dest(reg_write_dest),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write_enabled(wb_reg_write_enabled),
    .wb_reg_write_dest(wb_reg_write_dest), .wb_data(wb_data), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every wb_valid must match the oldest expected packet.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (mem_err && !wb_valid) begin
        checks++; errors++;
        $display("FAIL mem_err_without_wb: got 1 expected 0");
      end
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: got wb_valid=1 expected 0 (data 0x%0h)", wb_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_err", 32'(mem_err), 32'(e.err));
          chk("wb_we", 32'(wb_reg_write_enabled), 32'(e.we));
          if (!e.err) begin
            chk("wb_dest", 32'(wb_reg_write_dest), 32'(e.dest));
            chk("wb_data", wb_data, e.data);
          end
        end
      end
    end
  end

  task automatic push(input logic we, input logic [5:0] dest, input logic [31:0] d, input logic err);
    exp_t e;
    e.we = we; e.dest = dest; e.data = d; e.err = err;
    exp_q.push_back(e);
  endtask

  // Drive one transfer, waiting (bounded) for in_ready; returns at the next negedge.
  task automatic xfer(input logic [31:0] d, input logic [31:0] sd, input logic mr,
                      input logic mw, input logic rwe, input logic [5:0] dest);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_wait: got 0 expected 1 within 20 cycles");
    end
    data = d; store_data = sd; mem_read_enabled = mr; mem_write_enabled = mw;
    reg_write_enabled = rwe; reg_write_dest = dest; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; mem_read_enabled = 1'b0; mem_write_enabled = 1'b0;
  endtask

  // Hold the request for 'cycles' cycles, acking in the last one if ack_last.
  task automatic serve(input int cycles, input logic ack_last, input logic [31:0] rd,
                       input logic we, input logic [31:0] addr, input logic [31:0] wd);
    for (int i = 0; i < cycles; i++) begin
      chk("dmem_req_held", 32'(dmem_req), 32'd1);
      chk("in_ready_low", 32'(in_ready), 32'd0);
      chk("dmem_we", 32'(dmem_we), 32'(we));
      chk("dmem_addr", dmem_addr, addr);
      if (we) chk("dmem_wdata", dmem_wdata, wd);
      if (ack_last && i == cycles - 1) begin
        dmem_ack = 1'b1; dmem_rdata = rd;
      end
      @(negedge clk);
      dmem_ack = 1'b0; dmem_rdata = 32'hBAD0_BAD0;
    end
    chk("dmem_req_drop", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; data = '0; store_data = '0;
    mem_read_enabled = 1'b0; mem_write_enabled = 1'b0; reg_write_enabled = 1'b0;
    reg_write_dest = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // ALU result and x0 destination
    push(1'b1, 6'd5, 32'h10, 1'b0);
    xfer(32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 6'd5);
    push(1'b0, 6'd0, 32'h7, 1'b0);
    xfer(32'h7, 32'h0, 1'b0, 1'b0, 1'b1, 6'd0);
    // back-to-back ALU transfers
    push(1'b1, 6'd3, 32'hA, 1'b0);
    push(1'b0, 6'd4, 32'hB, 1'b0);
    xfer(32'hA, 32'h0, 1'b0, 1'b0, 1'b1, 6'd3);
    xfer(32'hB, 32'h0, 1'b0, 1'b0, 1'b0, 6'd4);
    chk("b2b_in_ready", 32'(in_ready), 32'd1);

    // load, ack after 3 cycles of request
    push(1'b1, 6'd7, 32'hDEADBEEF, 1'b0);
    xfer(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 6'd7);
    serve(3, 1'b1, 32'hDEADBEEF, 1'b0, 32'h100, 32'h0);

    // store: register write suppressed, wb_data carries the address
    push(1'b0, 6'd9, 32'h200, 1'b0);
    xfer(32'h200, 32'h55, 1'b0, 1'b1, 1'b1, 6'd9);
    serve(2, 1'b1, 32'h0, 1'b1, 32'h200, 32'h55);

    // misaligned store: no request, error with writeback
    push(1'b0, 6'd9, 32'h202, 1'b1);
    xfer(32'h202, 32'h66, 1'b0, 1'b1, 1'b1, 6'd9);
    chk("misaligned_no_req", 32'(dmem_req), 32'd0);

    // load+store together: store wins
    push(1'b0, 6'd11, 32'h300, 1'b0);
    xfer(32'h300, 32'h77, 1'b1, 1'b1, 1'b1, 6'd11);
    serve(1, 1'b1, 32'h9999, 1'b1, 32'h300, 32'h77);

    // timeout: request held 4 cycles then error
    push(1'b0, 6'd12, 32'h0, 1'b1);
    xfer(32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 6'd12);
    serve(4, 1'b0, 32'h0, 1'b0, 32'h400, 32'h0);

    // ack on the final allowed cycle completes normally
    push(1'b1, 6'd13, 32'h1234, 1'b0);
    xfer(32'h404, 32'h0, 1'b1, 1'b0, 1'b1, 6'd13);
    serve(4, 1'b1, 32'h1234, 1'b0, 32'h404, 32'h0);

    // reset during WAIT drops the request at once and emits nothing
    xfer(32'h500, 32'h0, 1'b1, 1'b0, 1'b1, 6'd14);
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_wait_req", 32'(dmem_req), 32'd0);
    chk("rst_wait_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", 32'(in_ready), 32'd1);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("stray_ack_no_req", 32'(dmem_req), 32'd0);
    repeat (4) @(negedge clk);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
